// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit saturating counters and update/mispredict statistics.
// Latency: lookup is combinational; updates and invalidation take effect at the next CLK edge.
// Backpressure: none; one lookup and one resolved-branch update are accepted every cycle.
module branch_predictor #(
  parameter int ENTRIES = 16
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] if_pc,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic        upd_en,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  input  logic [31:0] upd_target,
  input  logic        upd_pred_taken,
  input  logic [31:0] upd_pred_target,
  input  logic        inv,
  output logic        mispredict,
  output logic [31:0] br_cnt,
  output logic [31:0] miss_cnt
);

  localparam int IDXW = $clog2(ENTRIES);
  localparam int TAGW = 30 - IDXW;

  logic            valid_q  [ENTRIES];
  logic [TAGW-1:0] tag_q    [ENTRIES];
  logic [31:0]     target_q [ENTRIES];
  logic [1:0]      ctr_q    [ENTRIES];

  logic [IDXW-1:0] lk_idx;
  logic [TAGW-1:0] lk_tag;
  logic            lk_hit;
  logic [IDXW-1:0] up_idx;
  logic [TAGW-1:0] up_tag;
  logic            up_hit;
  logic [1:0]      up_ctr_nxt;

  // Byte offset bits of both PCs carry no information for word-aligned fetch.
  logic unused_pc_bits;
  assign unused_pc_bits = &{1'b0, if_pc[1:0], upd_pc[1:0]};

  assign lk_idx = if_pc[IDXW+1:2];
  assign lk_tag = if_pc[31:IDXW+2];
  assign up_idx = upd_pc[IDXW+1:2];
  assign up_tag = upd_pc[31:IDXW+2];

  // Fetch-side lookup reads the registered table only, so a same-cycle update is not bypassed.
  always_comb begin
    lk_hit      = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    pred_taken  = lk_hit && ctr_q[lk_idx][1];
    pred_target = pred_taken ? target_q[lk_idx] : (if_pc + 32'd4);
  end

  // Update-side hit check, saturating counter step and misprediction flag.
  always_comb begin
    up_hit     = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
    up_ctr_nxt = ctr_q[up_idx];
    if (upd_taken) begin
      if (ctr_q[up_idx] != 2'b11) up_ctr_nxt = ctr_q[up_idx] + 2'b01;
    end else begin
      if (ctr_q[up_idx] != 2'b00) up_ctr_nxt = ctr_q[up_idx] - 2'b01;
    end
    mispredict = upd_en && ((upd_taken != upd_pred_taken) ||
                            (upd_taken && (upd_pred_target != upd_target)));
  end

  // Table state: reset beats invalidate, invalidate beats a same-cycle update.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= 2'b01;
      end
    end else if (inv) begin
      for (int i = 0; i < ENTRIES; i++) valid_q[i] <= 1'b0;
    end else if (upd_en) begin
      if (up_hit) begin
        ctr_q[up_idx] <= up_ctr_nxt;
        if (upd_taken) target_q[up_idx] <= upd_target;
      end else if (upd_taken) begin
        valid_q[up_idx]  <= 1'b1;
        tag_q[up_idx]    <= up_tag;
        target_q[up_idx] <= upd_target;
        ctr_q[up_idx]    <= 2'b10;
      end
    end
  end

  // Statistics counters saturate and keep counting through invalidation.
  always_ff @(posedge CLK) begin
    if (RST) begin
      br_cnt   <= '0;
      miss_cnt <= '0;
    end else begin
      if (upd_en && (br_cnt != 32'hFFFF_FFFF)) br_cnt <= br_cnt + 32'd1;
      if (mispredict && (miss_cnt != 32'hFFFF_FFFF)) miss_cnt <= miss_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor with hand-computed expectations (ENTRIES=16).
// Latency: checks combinational outputs mid-cycle and registered state 1 ns after the edge.
// Backpressure: none; stimulus drives one update per cycle on the falling edge.
module tb_branch_predictor;

  logic        CLK = 1'b0;
  logic        RST;
  logic [31:0] if_pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        upd_en;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_pred_taken;
  logic [31:0] upd_pred_target;
  logic        inv;
  logic        mispredict;
  logic [31:0] br_cnt;
  logic [31:0] miss_cnt;

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] exp_br   = 0;
  logic [31:0] exp_miss = 0;

  branch_predictor #(.ENTRIES(16)) dut (
    .CLK(CLK), .RST(RST), .if_pc(if_pc), .pred_taken(pred_taken),
    .pred_target(pred_target), .upd_en(upd_en), .upd_pc(upd_pc),
    .upd_taken(upd_taken), .upd_target(upd_target),
    .upd_pred_taken(upd_pred_taken), .upd_pred_target(upd_pred_target),
    .inv(inv), .mispredict(mispredict), .br_cnt(br_cnt), .miss_cnt(miss_cnt)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", tag, got, exp);
  endtask

  // Present if_pc and compare the combinational prediction.
  task automatic look(input string tag, input logic [31:0] pc, input logic exp_t,
                      input logic [31:0] exp_tgt);
    if_pc = pc;
    #1;
    check({tag, ".taken"}, {31'd0, pred_taken}, {31'd0, exp_t});
    check({tag, ".target"}, pred_target, exp_tgt);
  endtask

  // One update cycle: drive at the falling edge, check mispredict, clock it, check counters.
  task automatic upd(input string tag, input logic [31:0] pc, input logic tk,
                     input logic [31:0] tgt, input logic ptk, input logic [31:0] ptgt,
                     input logic exp_mis, input logic with_inv);
    @(negedge CLK);
    upd_en = 1'b1; upd_pc = pc; upd_taken = tk; upd_target = tgt;
    upd_pred_taken = ptk; upd_pred_target = ptgt; inv = with_inv;
    #1;
    check({tag, ".mispredict"}, {31'd0, mispredict}, {31'd0, exp_mis});
    if (exp_br != 32'hFFFF_FFFF) exp_br = exp_br + 1;
    if (exp_mis && exp_miss != 32'hFFFF_FFFF) exp_miss = exp_miss + 1;
    @(posedge CLK);
    #1;
    upd_en = 1'b0; inv = 1'b0;
    check({tag, ".br_cnt"}, br_cnt, exp_br);
    check({tag, ".miss_cnt"}, miss_cnt, exp_miss);
  endtask

  initial begin
    RST = 1'b1; if_pc = 32'h40; upd_en = 1'b0; upd_pc = '0; upd_taken = 1'b0;
    upd_target = '0; upd_pred_taken = 1'b0; upd_pred_target = '0; inv = 1'b0;

    // Reset state
    repeat (2) @(posedge CLK);
    #1;
    look("rst_pred", 32'h40, 1'b0, 32'h44);
    check("rst_br", br_cnt, 32'd0);
    check("rst_miss", miss_cnt, 32'd0);
    @(negedge CLK);
    RST = 1'b0;

    // Allocation; same-cycle lookup still sees the old (empty) entry
    @(negedge CLK);
    upd_en = 1'b1; upd_pc = 32'h40; upd_taken = 1'b1; upd_target = 32'h100;
    upd_pred_taken = 1'b0; upd_pred_target = 32'h44;
    #1;
    look("nobypass", 32'h40, 1'b0, 32'h44);
    check("alloc.mispredict", {31'd0, mispredict}, 32'd1);
    @(posedge CLK);
    #1;
    upd_en = 1'b0;
    exp_br = 1; exp_miss = 1;
    check("alloc.br_cnt", br_cnt, exp_br);
    check("alloc.miss_cnt", miss_cnt, exp_miss);
    look("alloc", 32'h40, 1'b1, 32'h100);

    // Counter walk: 10 -> 11 -> 11 -> 11 -> 10 -> 01 -> 00 -> 00 -> 01 -> 10
    upd("t1", 32'h40, 1'b1, 32'h100, 1'b1, 32'h100, 1'b0, 1'b0); look("t1", 32'h40, 1'b1, 32'h100);
    upd("t2", 32'h40, 1'b1, 32'h100, 1'b1, 32'h100, 1'b0, 1'b0); look("t2", 32'h40, 1'b1, 32'h100);
    upd("t3", 32'h40, 1'b1, 32'h100, 1'b1, 32'h100, 1'b0, 1'b0); look("t3", 32'h40, 1'b1, 32'h100);
    upd("n1", 32'h40, 1'b0, 32'h100, 1'b1, 32'h100, 1'b1, 1'b0); look("n1", 32'h40, 1'b1, 32'h100);
    upd("n2", 32'h40, 1'b0, 32'h100, 1'b1, 32'h100, 1'b1, 1'b0); look("n2", 32'h40, 1'b0, 32'h44);
    upd("n3", 32'h40, 1'b0, 32'h100, 1'b0, 32'h44,  1'b0, 1'b0); look("n3", 32'h40, 1'b0, 32'h44);
    upd("n4", 32'h40, 1'b0, 32'h100, 1'b0, 32'h44,  1'b0, 1'b0); look("n4", 32'h40, 1'b0, 32'h44);
    upd("t4", 32'h40, 1'b1, 32'h100, 1'b0, 32'h44,  1'b1, 1'b0); look("t4", 32'h40, 1'b0, 32'h44);
    upd("t5", 32'h40, 1'b1, 32'h100, 1'b0, 32'h44,  1'b1, 1'b0); look("t5", 32'h40, 1'b1, 32'h100);

    // Aliasing: 0x80 shares index with 0x40 and evicts it
    upd("alias", 32'h80, 1'b1, 32'h200, 1'b0, 32'h84, 1'b1, 1'b0);
    look("alias_old", 32'h40, 1'b0, 32'h44);
    look("alias_new", 32'h80, 1'b1, 32'h200);

    // Hit with a new taken target rewrites the target; wrong target counts as a miss
    upd("retgt", 32'h80, 1'b1, 32'h300, 1'b1, 32'h200, 1'b1, 1'b0);
    look("retgt", 32'h80, 1'b1, 32'h300);

    // Not-taken miss leaves table alone; target mismatch on not-taken is not a mispredict
    upd("ntmiss", 32'h40, 1'b0, 32'h500, 1'b0, 32'h999, 1'b0, 1'b0);
    look("ntmiss_a", 32'h40, 1'b0, 32'h44);
    look("ntmiss_b", 32'h80, 1'b1, 32'h300);

    // Invalidate wins over a same-cycle update, counters still advance
    upd("inv", 32'h80, 1'b1, 32'h400, 1'b1, 32'h300, 1'b1, 1'b1);
    look("inv", 32'h80, 1'b0, 32'h84);

    // PC wrap on the fall-through target
    look("wrap", 32'hFFFF_FFFC, 1'b0, 32'h0);

    // Reset in the same cycle as an update discards it
    @(negedge CLK);
    RST = 1'b1; upd_en = 1'b1; upd_pc = 32'hC0; upd_taken = 1'b1; upd_target = 32'h600;
    upd_pred_taken = 1'b0; upd_pred_target = 32'hC4;
    @(posedge CLK);
    #1;
    upd_en = 1'b0; RST = 1'b0;
    exp_br = 0; exp_miss = 0;
    look("rstupd", 32'hC0, 1'b0, 32'hC4);
    check("rstupd.br_cnt", br_cnt, exp_br);
    check("rstupd.miss_cnt", miss_cnt, exp_miss);

    // Saturation of both statistics counters
    @(negedge CLK);
    dut.br_cnt = 32'hFFFF_FFFF;
    dut.miss_cnt = 32'hFFFF_FFFF;
    exp_br = 32'hFFFF_FFFF; exp_miss = 32'hFFFF_FFFF;
    upd("sat1", 32'h140, 1'b1, 32'h700, 1'b0, 32'h144, 1'b1, 1'b0);
    upd("sat2", 32'h140, 1'b1, 32'h800, 1'b1, 32'h700, 1'b1, 1'b0);
    look("sat", 32'h140, 1'b1, 32'h800);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 The module SHALL use one clock and a synchronous, active-high reset.
REQ-002 Parameter: ENTRIES, 16, number of BTB entries; power of two, 4..256; IDXW = log2(ENTRIES).
REQ-003 Port: CLK  input  1  clock; all state updates on its rising edge.
REQ-004 Port: RST  input  1  synchronous active-high reset.
REQ-005 Port: if_pc  input  32  fetch-stage PC to predict.
REQ-006 Port: pred_taken  output  1  predict taken for if_pc.
REQ-007 Port: pred_target  output  32  next fetch PC.
REQ-008 Port: upd_en  input  1  MEM stage resolved a conditional branch this cycle.
REQ-009 Port: upd_pc  input  32  PC of the resolved branch.
REQ-010 Port: upd_taken  input  1  actual branch outcome.
REQ-011 Port: upd_target  input  32  actual taken target.
REQ-012 Port: upd_pred_taken  input  1  prediction carried down the pipe with the branch.
REQ-013 Port: upd_pred_target  input  32  predicted next PC carried down the pipe.
REQ-014 Port: inv  input  1  invalidate the whole table.
REQ-015 Port: mispredict  output  1  combinational flag: the current update was mispredicted.
REQ-016 Port: br_cnt  output  32  count of accepted updates.
REQ-017 Port: miss_cnt  output  32  count of mispredicted updates.

Function
REQ-018 Each entry SHALL hold valid (1), tag (30-IDXW), target (32), ctr (2).
REQ-019 Index SHALL be pc[IDXW+1:2]; tag SHALL be pc[31:IDXW+2]; pc[1:0] SHALL be ignored.
REQ-020 Lookup SHALL be combinational: hit = valid[idx] and tag match.
REQ-021 pred_taken SHALL be hit and ctr[1]; pred_target SHALL be target when pred_taken, else if_pc+4 (mod 2^32; 0xFFFFFFFC -> 0x00000000).
REQ-022 ctr encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
REQ-023 On upd_en with update hit: ctr saturating +1 if upd_taken, saturating -1 otherwise; no change past 11 or below 00.
REQ-024 On upd_en with update hit and upd_taken: target SHALL be written with upd_target.
REQ-025 On upd_en with update miss and upd_taken: allocate (overwrite) entry: valid=1, tag, target=upd_target, ctr=10.
REQ-026 On upd_en with update miss and not upd_taken: table SHALL be unchanged.
REQ-027 mispredict SHALL be upd_en and ((upd_taken != upd_pred_taken) or (upd_taken and upd_pred_target != upd_target)).
REQ-028 br_cnt SHALL increment on every upd_en; miss_cnt SHALL increment when mispredict; both saturate at 0xFFFFFFFF.
REQ-029 A lookup and an update to the same index in one cycle: lookup SHALL return pre-update contents (no bypass); new contents visible the next cycle.
REQ-030 inv SHALL clear all valid bits at the clock edge and take priority over a same-cycle table update; counters (br_cnt/miss_cnt) still update from upd_en.
REQ-031 Invalidated entries SHALL not hit; ctr/target contents are don't-care until reallocation.

Reset
REQ-032 On RST at a clock edge: all valid=0, all ctr=01, all target=0, br_cnt=0, miss_cnt=0; RST overrides inv and upd_en.
REQ-033 During and after reset, with no updates: pred_taken=0, pred_target=if_pc+4.
REQ-034 RST asserted mid-sequence SHALL discard any update presented in that cycle.

Verification
REQ-035 After reset, if_pc=0x00000040 -> pred_taken=0, pred_target=0x00000044, br_cnt=0.
REQ-036 upd_en, upd_pc=0x40, upd_taken=1, upd_target=0x100, upd_pred_taken=0 -> mispredict=1; next cycle if_pc=0x40 gives pred_taken=1, pred_target=0x100, br_cnt=1, miss_cnt=1.
REQ-037 Three further taken updates to 0x40 then three not-taken -> ctr path 10,11,11,11,10,01,00; pred_taken goes 0 after the fifth update.
REQ-038 Aliasing: allocate 0x40, then taken update at 0x40+4*ENTRIES target 0x200 -> 0x40 misses, alias hits with target 0x200.
REQ-039 Same cycle inv=1 and taken update at 0x80 -> next cycle no hit at 0x80, br_cnt incremented.
REQ-040 if_pc=0xFFFFFFFC, miss -> pred_target=0x00000000; counters forced to 0xFFFFFFFF stay saturated on further updates.
